alu_result_queue: RTL and testbench

- Completion-side buffer directly downstream of the ALU execution unit inside an ALU combo.
- Captures finished ALU results, each tagged with its destination rename tag, into a small FIFO.
- Requests slots on the two common data bus lanes and drives up to two results per cycle onto the lanes the bus arbiter grants.
- Decouples ALU completion from CDB availability; back-pressures the reservation station through in_ready.

---
 rtl/alu_result_queue.sv | 118 +++++++++++
 tb/tb_alu_result_queue.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_queue.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_queue
// Purpose  : Completion-side buffer behind the ALU. Holds finished results
//            with their rename tags in a small FIFO, requests common data bus
//            lanes, and drives up to two results per cycle on granted lanes.
// Ports    : clk, reset_n (async active-low), flush (sync discard)
//            in_valid/in_ready/in_result/in_tag : ALU completion side
//            bus_req[1:0], bus_grant[1:0]       : CDB arbiter handshake
//            cdb_valid/cdb_result/cdb_tag       : two CDB lanes
//            count, full                        : occupancy status
// Revision : 1.0  initial release
// ============================================================================
module alu_result_queue #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 6,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_result,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    output logic [1:0]                 bus_req,
    input  logic [1:0]                 bus_grant,
    output logic [1:0]                 cdb_valid,
    output logic [2*XLEN-1:0]          cdb_result,
    output logic [2*TAG_WIDTH-1:0]     cdb_tag,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [XLEN-1:0]      r_mem_result [DEPTH];
    logic [TAG_WIDTH-1:0] r_mem_tag    [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_has_one;
    logic                 w_has_two;
    logic                 w_push;
    logic [1:0]           w_pop_cnt;
    logic [c_PTR_W-1:0]   w_lane_idx   [2];
    logic [1:0]           w_lane_avail;

    assign w_has_one = (r_count >= c_CNT_W'(1));
    assign w_has_two = (r_count >= c_CNT_W'(2));

    // No pop bypass: a full queue refuses input even when a pop happens.
    assign in_ready = (r_count < c_CNT_W'(DEPTH));
    assign full     = (r_count == c_CNT_W'(DEPTH));
    assign count    = r_count;
    assign bus_req  = {w_has_two, w_has_one};

    // Flush wins over push; the offered result is simply dropped.
    assign w_push = in_valid && in_ready && !flush;

    // Lane 0 always takes the head when granted. Lane 1 takes the head when
    // it is the only granted lane, otherwise the entry behind the head.
    always_comb begin
        w_lane_idx[0]   = r_rd_ptr;
        w_lane_avail[0] = w_has_one;
        if (bus_grant[0]) begin
            w_lane_idx[1]   = r_rd_ptr + c_PTR_W'(1);
            w_lane_avail[1] = w_has_two;
        end else begin
            w_lane_idx[1]   = r_rd_ptr;
            w_lane_avail[1] = w_has_one;
        end
    end

    generate
        for (genvar i = 0; i < 2; i++) begin : g_lane
            assign cdb_valid[i] = bus_grant[i] && w_lane_avail[i] && !flush;
            assign cdb_result[i*XLEN +: XLEN] =
                cdb_valid[i] ? r_mem_result[w_lane_idx[i]] : '0;
            assign cdb_tag[i*TAG_WIDTH +: TAG_WIDTH] =
                cdb_valid[i] ? r_mem_tag[w_lane_idx[i]] : '0;
        end
    endgenerate

    assign w_pop_cnt = {1'b0, cdb_valid[0]} + {1'b0, cdb_valid[1]};

    // Pointer/occupancy state. Pointers wrap naturally because DEPTH is a
    // power of two; a pop of 2 truncated to a 1-bit pointer still wraps right.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_pop_cnt);
            r_count  <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop_cnt);
        end
    end

    // Storage needs no reset; entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_result[r_wr_ptr] <= in_result;
            r_mem_tag[r_wr_ptr]    <= in_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_queue
// Purpose  : Directed self-checking bench for alu_result_queue (DEPTH 4).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_result_queue;

    localparam int XLEN      = 32;
    localparam int TAG_WIDTH = 6;
    localparam int DEPTH     = 4;

    logic                   clk;
    logic                   reset_n;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [XLEN-1:0]        in_result;
    logic [TAG_WIDTH-1:0]   in_tag;
    logic [1:0]             bus_req;
    logic [1:0]             bus_grant;
    logic [1:0]             cdb_valid;
    logic [2*XLEN-1:0]      cdb_result;
    logic [2*TAG_WIDTH-1:0] cdb_tag;
    logic [2:0]             count;
    logic                   full;

    int n_checks = 0;
    int n_fails  = 0;

    alu_result_queue #(
        .XLEN      (XLEN),
        .TAG_WIDTH (TAG_WIDTH),
        .DEPTH     (DEPTH)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_tag     (in_tag),
        .bus_req    (bus_req),
        .bus_grant  (bus_grant),
        .cdb_valid  (cdb_valid),
        .cdb_result (cdb_result),
        .cdb_tag    (cdb_tag),
        .count      (count),
        .full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then confirm in_ready == !full.
    task automatic tick();
        @(posedge clk);
        #1;
        check_eq("ready_vs_full", {63'd0, in_ready}, {63'd0, ~full});
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input logic [XLEN-1:0] d, input logic [TAG_WIDTH-1:0] t);
        in_valid  = 1'b1;
        in_result = d;
        in_tag    = t;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic check_lanes(input string tag, input logic [1:0] v,
                               input logic [31:0] r0, input logic [5:0] t0,
                               input logic [31:0] r1, input logic [5:0] t1);
        check_eq({tag, "_valid"}, {62'd0, cdb_valid}, {62'd0, v});
        check_eq({tag, "_res0"},  {32'd0, cdb_result[31:0]},  {32'd0, r0});
        check_eq({tag, "_tag0"},  {58'd0, cdb_tag[5:0]},      {58'd0, t0});
        check_eq({tag, "_res1"},  {32'd0, cdb_result[63:32]}, {32'd0, r1});
        check_eq({tag, "_tag1"},  {58'd0, cdb_tag[11:6]},     {58'd0, t1});
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_tag    = '0;
        bus_grant = 2'b00;

        // ---- reset / idle ----
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_count",   {61'd0, count},     64'd0);
        check_eq("rst_ready",   {63'd0, in_ready},  64'd1);
        check_eq("rst_full",    {63'd0, full},      64'd0);
        check_eq("rst_busreq",  {62'd0, bus_req},   64'd0);
        check_eq("rst_cdbv",    {62'd0, cdb_valid}, 64'd0);
        reset_n = 1'b1;
        tick();
        check_eq("idle_count",  {61'd0, count},     64'd0);
        check_eq("idle_busreq", {62'd0, bus_req},   64'd0);

        // ---- single flow; grant during push cycle must not bypass ----
        in_valid  = 1'b1;
        in_result = 32'h0000_00AA;
        in_tag    = 6'd5;
        bus_grant = 2'b01;
        settle();
        check_eq("sf_nobypass_v", {62'd0, cdb_valid}, 64'd0);
        check_eq("sf_nobypass_r", {62'd0, bus_req},   64'd0);
        tick();
        in_valid = 1'b0;
        settle();
        check_eq("sf_busreq", {62'd0, bus_req}, 64'd1);
        check_lanes("sf", 2'b01, 32'hAA, 6'd5, 32'h0, 6'd0);
        tick();
        bus_grant = 2'b00;
        check_eq("sf_count", {61'd0, count}, 64'd0);

        // ---- pre-advance pointers from 1 to 3 ----
        push(32'h1111, 6'd1);
        push(32'h2222, 6'd2);
        bus_grant = 2'b11;
        settle();
        check_lanes("pre", 2'b11, 32'h1111, 6'd1, 32'h2222, 6'd2);
        tick();
        bus_grant = 2'b00;
        check_eq("pre_count", {61'd0, count}, 64'd0);

        // ---- dual pop across the wrap: A@3, B@0, C@1 ----
        push(32'hA0A0_0001, 6'd10);
        push(32'hB0B0_0002, 6'd11);
        push(32'hC0C0_0003, 6'd12);
        check_eq("wrap_busreq", {62'd0, bus_req}, 64'd3);
        bus_grant = 2'b11;
        settle();
        check_lanes("wrap_ab", 2'b11, 32'hA0A0_0001, 6'd10, 32'hB0B0_0002, 6'd11);
        tick();
        check_eq("wrap_count1", {61'd0, count}, 64'd1);
        bus_grant = 2'b10;
        settle();
        check_lanes("wrap_c", 2'b10, 32'h0, 6'd0, 32'hC0C0_0003, 6'd12);
        tick();
        bus_grant = 2'b00;
        check_eq("wrap_count0", {61'd0, count}, 64'd0);

        // grant with nothing queued
        bus_grant = 2'b10;
        settle();
        check_eq("empty_grant_v", {62'd0, cdb_valid}, 64'd0);
        tick();
        bus_grant = 2'b00;
        check_eq("empty_grant_cnt", {61'd0, count}, 64'd0);

        // ---- fill and back-pressure ----
        push(32'hD000_0000, 6'd20);
        push(32'hD000_0001, 6'd21);
        push(32'hD000_0002, 6'd22);
        push(32'hD000_0003, 6'd23);
        check_eq("full_flag",  {63'd0, full},     64'd1);
        check_eq("full_ready", {63'd0, in_ready}, 64'd0);
        check_eq("full_count", {61'd0, count},    64'd4);
        in_valid  = 1'b1;
        in_result = 32'hEEEE_0000;
        in_tag    = 6'd30;
        bus_grant = 2'b01;
        settle();
        check_eq("bp_ready", {63'd0, in_ready}, 64'd0);
        check_lanes("bp_pop", 2'b01, 32'hD000_0000, 6'd20, 32'h0, 6'd0);
        tick();
        bus_grant = 2'b00;
        check_eq("bp_count", {61'd0, count}, 64'd3);
        tick();                                   // E retried and accepted
        in_valid = 1'b0;
        check_eq("bp_accept", {61'd0, count}, 64'd4);

        // drain two: D1, D2 -> count 2 (D3, E)
        bus_grant = 2'b11;
        settle();
        check_lanes("drain", 2'b11, 32'hD000_0001, 6'd21, 32'hD000_0002, 6'd22);
        tick();
        check_eq("drain_count", {61'd0, count}, 64'd2);

        // ---- simultaneous push + dual pop at count 2 ----
        in_valid  = 1'b1;
        in_result = 32'hF00D_0001;
        in_tag    = 6'd40;
        settle();
        check_lanes("pp", 2'b11, 32'hD000_0003, 6'd23, 32'hEEEE_0000, 6'd30);
        tick();
        in_valid  = 1'b0;
        bus_grant = 2'b01;
        check_eq("pp_count", {61'd0, count}, 64'd1);
        settle();
        check_lanes("pp_new", 2'b01, 32'hF00D_0001, 6'd40, 32'h0, 6'd0);
        tick();
        bus_grant = 2'b00;
        check_eq("pp_count0", {61'd0, count}, 64'd0);

        // ---- flush with grants and input ----
        push(32'h6666_0001, 6'd1);
        push(32'h6666_0002, 6'd2);
        push(32'h6666_0003, 6'd3);
        check_eq("fl_pre_count", {61'd0, count}, 64'd3);
        flush     = 1'b1;
        bus_grant = 2'b11;
        in_valid  = 1'b1;
        in_result = 32'h7777_7777;
        in_tag    = 6'd7;
        settle();
        check_eq("fl_cdbv",  {62'd0, cdb_valid},  64'd0);
        check_eq("fl_res",   cdb_result,          64'd0);
        check_eq("fl_ready", {63'd0, in_ready},   64'd1);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        bus_grant = 2'b00;
        check_eq("fl_count",  {61'd0, count},   64'd0);
        check_eq("fl_busreq", {62'd0, bus_req}, 64'd0);

        // ---- bad grant 11 with count 1 ----
        push(32'h8888_0001, 6'd9);
        bus_grant = 2'b11;
        settle();
        check_lanes("bad", 2'b01, 32'h8888_0001, 6'd9, 32'h0, 6'd0);
        tick();
        bus_grant = 2'b00;
        check_eq("bad_count",  {61'd0, count},   64'd0);
        check_eq("bad_busreq", {62'd0, bus_req}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
